// File: rtl/midi_msg_decoder.sv
// midi_msg_decoder: rebuilds complete MIDI messages from the UART byte stream and queues them in a show-ahead FIFO.
// Latency: msg_valid rises 4 CLOCK_50 edges after the edge that first samples byteready=1 on the completing byte (empty FIFO).
// Backpressure: head is held while msg_ready is low; a message completing into a full FIFO with no pop is dropped and sets fifo_overflow.
//
// Ports:
//   CLOCK_50, reset_reg_N (async, active-low)
//   byteready, midi_in_data    : UART byte strobe (asynchronous, long pulse) and received byte
//   msg_valid, msg_ready       : FIFO head handshake
//   msg_status/data1/data2/len : head message fields, zero when the FIFO is empty
//   fifo_overflow              : sticky drop indicator
//   running_status             : status byte currently in force, 0 = none
module midi_msg_decoder #(
    parameter int         FIFO_DEPTH       = 4,
    parameter bit         OMNI             = 1'b1,
    parameter logic [3:0] CHANNEL          = 4'd0,
    parameter bit         NOTEON_V0_AS_OFF = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset_reg_N,
    input  logic       byteready,
    input  logic [7:0] midi_in_data,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       fifo_overflow,
    output logic [7:0] running_status
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0] status;
        logic [6:0] data1;
        logic [6:0] data2;
        logic [1:0] len;
    } msg_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_D1    = 2'd1,
        WAIT_D2    = 2'd2,
        SKIP_SYSEX = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Byte capture: two synchronizer flops plus an edge flop; a held
    // byteready yields a single strobe on its rising edge.
    // ------------------------------------------------------------------
    logic [2:0] sync_q;
    logic       byte_stb;
    logic       byte_vld_q;
    logic [7:0] byte_q;

    assign byte_stb = sync_q[1] & ~sync_q[2];

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            sync_q     <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
        end else begin
            sync_q     <= {sync_q[1:0], byteready};
            byte_vld_q <= byte_stb;
            if (byte_stb) begin
                byte_q <= midi_in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Parser
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] rs_q, rs_d;
    logic [6:0] d1_q, d1_d;
    logic       push_q, push_d;
    msg_t       push_msg_q, push_msg_d;

    logic       need_two;
    logic       chan_ok;
    logic       done;
    logic [6:0] done_d1;
    logic [6:0] done_d2;
    logic [1:0] done_len;

    always_comb begin
        need_two = (rs_q == 8'hF2) ||
                   (rs_q[7:4] inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hE});
        // System messages bypass the channel filter.
        chan_ok  = (rs_q[7:4] == 4'hF) || OMNI || (rs_q[3:0] == CHANNEL);
    end

    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        d1_d       = d1_q;
        push_d     = 1'b0;
        push_msg_d = '0;
        done       = 1'b0;
        done_d1    = '0;
        done_d2    = '0;
        done_len   = '0;

        if (byte_vld_q) begin
            if (byte_q >= 8'hF8) begin
                // Realtime: queue immediately, parser context untouched.
                push_d            = 1'b1;
                push_msg_d.status = byte_q;
            end else if (byte_q[7]) begin
                // Any other status byte abandons a partial message.
                d1_d = '0;
                if (byte_q < 8'hF0) begin
                    rs_d    = byte_q;
                    state_d = WAIT_D1;
                end else begin
                    rs_d    = 8'h00;
                    state_d = IDLE;
                    case (byte_q)
                        8'hF0: state_d = SKIP_SYSEX;
                        // System common with data: held in rs_q only until complete.
                        8'hF1, 8'hF2, 8'hF3: begin
                            rs_d    = byte_q;
                            state_d = WAIT_D1;
                        end
                        8'hF6: begin
                            push_d            = 1'b1;
                            push_msg_d.status = byte_q;
                        end
                        default: ;
                    endcase
                end
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        if (need_two) begin
                            d1_d    = byte_q[6:0];
                            state_d = WAIT_D2;
                        end else begin
                            done     = 1'b1;
                            done_d1  = byte_q[6:0];
                            done_len = 2'd1;
                        end
                    end
                    WAIT_D2: begin
                        done     = 1'b1;
                        done_d1  = d1_q;
                        done_d2  = byte_q[6:0];
                        done_len = 2'd2;
                    end
                    default: ;
                endcase
            end
        end

        if (done) begin
            push_d           = chan_ok;
            push_msg_d.data1 = done_d1;
            push_msg_d.data2 = done_d2;
            push_msg_d.len   = done_len;
            if (NOTEON_V0_AS_OFF && (rs_q[7:4] == 4'h9) && (done_len == 2'd2) &&
                (done_d2 == 7'd0)) begin
                push_msg_d.status = {4'h8, rs_q[3:0]};
            end else begin
                push_msg_d.status = rs_q;
            end
            d1_d = '0;
            if (rs_q[7:4] == 4'hF) begin
                rs_d    = 8'h00;
                state_d = IDLE;
            end else begin
                state_d = WAIT_D1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q    <= IDLE;
            rs_q       <= '0;
            d1_q       <= '0;
            push_q     <= 1'b0;
            push_msg_q <= '0;
        end else begin
            state_q    <= state_d;
            rs_q       <= rs_d;
            d1_q       <= d1_d;
            push_q     <= push_d;
            push_msg_q <= push_msg_d;
        end
    end

    // ------------------------------------------------------------------
    // Message FIFO (show-ahead)
    // ------------------------------------------------------------------
    msg_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          fifo_full;
    logic          do_pop;
    logic          do_push;
    msg_t          head;

    assign fifo_full = (cnt_q == FULL_CNT);
    assign msg_valid = (cnt_q != '0);
    assign do_pop    = msg_valid & msg_ready;
    // A pop on the same edge frees the slot the push needs.
    assign do_push   = push_q & (~fifo_full | do_pop);

    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_msg_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
            if (push_q && !do_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign msg_status     = msg_valid ? head.status : 8'h00;
    assign msg_data1      = msg_valid ? head.data1  : 7'h00;
    assign msg_data2      = msg_valid ? head.data2  : 7'h00;
    assign msg_len        = msg_valid ? head.len    : 2'd0;
    assign fifo_overflow  = ovf_q;
    assign running_status = rs_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// tb_midi_msg_decoder: table-driven and randomized checks of midi_msg_decoder.
// Latency: n/a (testbench).
// Backpressure: msg_ready driven by the bench (fixed, toggled, or random).
module tb_midi_msg_decoder;

    logic       CLOCK_50;
    logic       reset_reg_N;
    logic       byteready;
    logic [7:0] midi_in_data;
    logic       msg_ready;
    logic       msg_valid;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic [1:0] msg_len;
    logic       fifo_overflow;
    logic [7:0] running_status;

    // Second instance: OMNI=0, CHANNEL=2, always ready.
    logic       msg_ready2;
    logic       msg_valid2;
    logic [7:0] msg_status2;
    logic [6:0] msg_data1_2;
    logic [6:0] msg_data2_2;
    logic [1:0] msg_len2;
    logic       fifo_overflow2;
    logic [7:0] running_status2;

    midi_msg_decoder #(.FIFO_DEPTH(4), .OMNI(1'b1), .CHANNEL(4'd0), .NOTEON_V0_AS_OFF(1'b1)) dut (
        .CLOCK_50(CLOCK_50), .reset_reg_N(reset_reg_N), .byteready(byteready),
        .midi_in_data(midi_in_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
        .msg_len(msg_len), .fifo_overflow(fifo_overflow), .running_status(running_status)
    );

    midi_msg_decoder #(.FIFO_DEPTH(4), .OMNI(1'b0), .CHANNEL(4'd2), .NOTEON_V0_AS_OFF(1'b1)) dut2 (
        .CLOCK_50(CLOCK_50), .reset_reg_N(reset_reg_N), .byteready(byteready),
        .midi_in_data(midi_in_data), .msg_valid(msg_valid2), .msg_ready(msg_ready2),
        .msg_status(msg_status2), .msg_data1(msg_data1_2), .msg_data2(msg_data2_2),
        .msg_len(msg_len2), .fifo_overflow(fifo_overflow2), .running_status(running_status2)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int n_chk  = 0;
    int n_pass = 0;
    bit rand_rdy = 1'b0;

    logic [23:0] got_q[$];
    logic [23:0] got2_q[$];

    // Popped messages, sampled mid-cycle; inputs only change just after posedge.
    always @(negedge CLOCK_50) begin
        if (msg_valid && msg_ready)
            got_q.push_back({msg_status, msg_data1, msg_data2, msg_len});
        if (msg_valid2 && msg_ready2)
            got2_q.push_back({msg_status2, msg_data1_2, msg_data2_2, msg_len2});
    end

    function automatic logic [23:0] mk(input logic [7:0] s, input logic [6:0] a,
                                       input logic [6:0] b, input logic [1:0] l);
        return {s, a, b, l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLOCK_50); #1;
            if (rand_rdy) msg_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLOCK_50); #1;
        midi_in_data = b;
        byteready    = 1'b1;
        cycles(30);
        byteready = 1'b0;
        cycles(12);
    endtask

    task automatic do_reset();
        @(posedge CLOCK_50); #1;
        byteready   = 1'b0;
        reset_reg_N = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 reset_reg_N = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: collects data bytes per status and emits a message
    // once the count that status requires has been collected.
    // ------------------------------------------------------------------
    logic [7:0]  m_rs;
    bit          m_sysex;
    logic [6:0]  m_col[$];
    logic [23:0] exp_q[$];

    function automatic int need_cnt(input logic [7:0] s);
        if (s == 8'hF2) return 2;
        if (s == 8'hF1 || s == 8'hF3) return 1;
        if (s[7:4] == 4'hC || s[7:4] == 4'hD) return 1;
        return 2;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] st;
        logic [6:0] a;
        logic [6:0] c;
        if (b >= 8'hF8) begin
            exp_q.push_back(mk(b, 7'd0, 7'd0, 2'd0));
        end else if (b >= 8'h80) begin
            m_col.delete();
            m_sysex = (b == 8'hF0);
            if (b < 8'hF0 || b == 8'hF1 || b == 8'hF2 || b == 8'hF3) m_rs = b;
            else m_rs = 8'h00;
            if (b == 8'hF6) exp_q.push_back(mk(b, 7'd0, 7'd0, 2'd0));
        end else if (!m_sysex && m_rs != 8'h00) begin
            m_col.push_back(b[6:0]);
            if (m_col.size() == need_cnt(m_rs)) begin
                st = m_rs;
                a  = m_col[0];
                c  = (m_col.size() == 2) ? m_col[1] : 7'd0;
                if (st[7:4] == 4'h9 && m_col.size() == 2 && c == 7'd0) st = {4'h8, m_rs[3:0]};
                exp_q.push_back(mk(st, a, c, 2'(m_col.size())));
                m_col.delete();
                if (m_rs >= 8'hF0) m_rs = 8'h00;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [47:0] b;      // bytes, first in [47:40]
        int          nb;
        int          nexp;
        logic [23:0] e0;
        logic [23:0] e1;
        logic [7:0]  rs;
    } vec_t;

    vec_t tbl[13];

    task automatic set_vec(input int i, input logic [47:0] b, input int nb, input int nexp,
                           input logic [23:0] e0, input logic [23:0] e1, input logic [7:0] rs);
        tbl[i].b = b; tbl[i].nb = nb; tbl[i].nexp = nexp;
        tbl[i].e0 = e0; tbl[i].e1 = e1; tbl[i].rs = rs;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rb;
        int         r;

        reset_reg_N  = 1'b0;
        byteready    = 1'b0;
        midi_in_data = 8'h00;
        msg_ready    = 1'b1;
        msg_ready2   = 1'b1;

        set_vec(0,  48'h903C64000000, 3, 1, mk(8'h90, 7'h3C, 7'h64, 2'd2), 24'h0, 8'h90);
        set_vec(1,  48'h903C64400000, 5, 2, mk(8'h90, 7'h3C, 7'h64, 2'd2), mk(8'h80, 7'h40, 7'h00, 2'd2), 8'h90);
        set_vec(2,  48'hB007F87F0000, 4, 2, mk(8'hF8, 7'h00, 7'h00, 2'd0), mk(8'hB0, 7'h07, 7'h7F, 2'd2), 8'hB0);
        set_vec(3,  48'hF04312F72200, 5, 0, 24'h0, 24'h0, 8'h00);
        set_vec(4,  48'hC30500000000, 2, 1, mk(8'hC3, 7'h05, 7'h00, 2'd1), 24'h0, 8'hC3);
        set_vec(5,  48'hF20102000000, 3, 1, mk(8'hF2, 7'h01, 7'h02, 2'd2), 24'h0, 8'h00);
        set_vec(6,  48'hF13300000000, 2, 1, mk(8'hF1, 7'h33, 7'h00, 2'd1), 24'h0, 8'h00);
        set_vec(7,  48'hF60000000000, 1, 1, mk(8'hF6, 7'h00, 7'h00, 2'd0), 24'h0, 8'h00);
        set_vec(8,  48'hF42200000000, 2, 0, 24'h0, 24'h0, 8'h00);
        set_vec(9,  48'hE51020F51100, 5, 1, mk(8'hE5, 7'h10, 7'h20, 2'd2), 24'h0, 8'h00);
        set_vec(10, 48'hA110B2203000, 5, 1, mk(8'hB2, 7'h20, 7'h30, 2'd2), 24'h0, 8'hB2);
        set_vec(11, 48'h913C00000000, 3, 1, mk(8'h81, 7'h3C, 7'h00, 2'd2), 24'h0, 8'h91);
        set_vec(12, 48'hFE0000000000, 1, 1, mk(8'hFE, 7'h00, 7'h00, 2'd0), 24'h0, 8'h91);

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("reset msg_valid", msg_valid, 0);
        chk("reset fields", {msg_status, msg_data1, msg_data2, msg_len}, 0);
        chk("reset fifo_overflow", fifo_overflow, 0);
        chk("reset running_status", running_status, 0);
        @(posedge CLOCK_50); #1 reset_reg_N = 1'b1;
        repeat (2) @(posedge CLOCK_50); #1;

        // Table
        for (int i = 0; i < 13; i++) begin
            got_q.delete();
            for (int j = 0; j < tbl[i].nb; j++) send_byte(tbl[i].b[47-8*j -: 8]);
            chk($sformatf("tbl%0d count", i), got_q.size(), tbl[i].nexp);
            if (tbl[i].nexp >= 1)
                chk($sformatf("tbl%0d msg0", i), got_q.size() > 0 ? got_q[0] : 24'hFFFFFF, tbl[i].e0);
            if (tbl[i].nexp >= 2)
                chk($sformatf("tbl%0d msg1", i), got_q.size() > 1 ? got_q[1] : 24'hFFFFFF, tbl[i].e1);
            chk($sformatf("tbl%0d running_status", i), running_status, tbl[i].rs);
        end

        // Latency, head stability, single-cycle valid, held byteready
        send_byte(8'hC0);
        got_q.delete();
        @(posedge CLOCK_50); #1;
        msg_ready    = 1'b0;
        midi_in_data = 8'h11;
        byteready    = 1'b1;
        @(posedge CLOCK_50);               // first edge sampling byteready=1
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("latency edge3 msg_valid", msg_valid, 0);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("latency edge4 msg_valid", msg_valid, 1);
        chk("latency head", {msg_status, msg_data1, msg_data2, msg_len}, mk(8'hC0, 7'h11, 7'h00, 2'd1));
        repeat (5) @(negedge CLOCK_50);
        chk("stall head stable", {msg_status, msg_data1, msg_data2, msg_len}, mk(8'hC0, 7'h11, 7'h00, 2'd1));
        @(posedge CLOCK_50); #1 msg_ready = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("valid one cycle", msg_valid, 0);
        repeat (40) @(posedge CLOCK_50);
        #1 byteready = 1'b0;
        repeat (12) @(posedge CLOCK_50); #1;
        chk("held byteready one message", got_q.size(), 1);

        // Randomized against the model
        do_reset();
        got_q.delete();
        exp_q.delete();
        m_col.delete();
        m_rs    = 8'h00;
        m_sysex = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       rb = 8'h00;
            else if (r < 55) rb = 8'($urandom_range(0, 127));
            else if (r < 80) rb = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 86) rb = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 90) rb = 8'hF0;
            else if (r < 93) rb = 8'hF7;
            else             rb = 8'($urandom_range(8'hF1, 8'hF6));
            send_byte(rb);
            model_byte(rb);
            chk($sformatf("rand%0d running_status", i), running_status, m_rs);
        end
        rand_rdy  = 1'b0;
        msg_ready = 1'b1;
        repeat (20) @(posedge CLOCK_50); #1;
        chk("rand message count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("rand msg%0d", i), got_q.size() > i ? got_q[i] : 24'hFFFFFF, exp_q[i]);
        chk("rand no overflow", fifo_overflow, 0);

        // Overflow: five program changes into a depth-4 FIFO
        do_reset();
        msg_ready = 1'b0;
        send_byte(8'hC0);
        for (int n = 1; n <= 5; n++) send_byte(8'(n));
        chk("ovf sticky flag", fifo_overflow, 1);
        chk("ovf head", {msg_status, msg_data1, msg_data2, msg_len}, mk(8'hC0, 7'd1, 7'd0, 2'd1));
        got_q.delete();
        @(posedge CLOCK_50); #1 msg_ready = 1'b1;
        repeat (10) @(posedge CLOCK_50); #1;
        chk("ovf drained count", got_q.size(), 4);
        for (int n = 0; n < 4; n++)
            chk($sformatf("ovf order%0d", n), got_q.size() > n ? got_q[n] : 24'hFFFFFF, mk(8'hC0, 7'(n + 1), 7'd0, 2'd1));
        @(negedge CLOCK_50);
        chk("ovf empty valid", msg_valid, 0);
        chk("ovf empty fields", {msg_status, msg_data1, msg_data2, msg_len}, 0);
        chk("ovf flag still set", fifo_overflow, 1);
        do_reset();
        chk("ovf cleared by reset", fifo_overflow, 0);

        // Channel filter on the OMNI=0, CHANNEL=2 instance
        got2_q.delete();
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h92); send_byte(8'h3C); send_byte(8'h64);
        chk("filter count", got2_q.size(), 1);
        chk("filter msg", got2_q.size() > 0 ? got2_q[0] : 24'hFFFFFF, mk(8'h92, 7'h3C, 7'h64, 2'd2));
        chk("filter running_status", running_status2, 8'h92);

        // Reset mid-message
        got2_q.delete();
        send_byte(8'h92); send_byte(8'h3C);
        do_reset();
        send_byte(8'h64);
        chk("reset mid-msg no output", got2_q.size(), 0);
        chk("reset mid-msg running_status", running_status2, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
